// File: rtl/conv_mac_window.sv
// Sequential multiply-accumulate for one convolution output: TAPS Q5.11 pixel/weight beats
// are multiplied at full precision, summed in a wide accumulator and saturated to one Q5.11 word.
module conv_mac_window #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 11,
    parameter int unsigned TAPS   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic [DATA_W-1:0] in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(TAPS) + 1;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    // Lowest accumulator bit that must equal the sign for the sum to fit the result word.
    localparam int unsigned HI_LSB = DATA_W + FRAC_W - 1;

    typedef enum logic [1:0] {StAccum, StFlush, StHold} state_e;

    state_e                    state_q, state_d;
    logic        [CNT_W-1:0]   tap_cnt_q, tap_cnt_d;
    logic        [1:0]         flush_cnt_q, flush_cnt_d;
    logic signed [PROD_W-1:0]  prod_r_q, prod_r_d;
    logic                      prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      out_valid_q, out_valid_d;
    logic        [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      accept;
    logic                      in_range;
    logic        [DATA_W-1:0]  sat_data;

    always_comb begin
        in_range = (&acc_q[ACC_W-1:HI_LSB]) || (~|acc_q[ACC_W-1:HI_LSB]);
        if (in_range) begin
            sat_data = acc_q[HI_LSB:FRAC_W];
        end else if (acc_q[ACC_W-1]) begin
            sat_data = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_data = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        in_ready    = 1'b0;

        if (state_q == StAccum) begin
            in_ready = !rst;
        end
        accept = in_ready && in_valid;

        prod_v_d = accept;
        prod_r_d = accept ? $signed(in_pixel) * $signed(in_weight) : prod_r_q;
        acc_d    = acc_q;
        if (prod_v_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod_r_q[PROD_W-1]}}, prod_r_q};
        end

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (tap_cnt_q == CNT_W'(TAPS - 1)) begin
                        tap_cnt_d = '0;
                        state_d   = StFlush;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                // Drains product and accumulate stages; result registers 3 edges after last beat.
                if (flush_cnt_q == 2'd2) begin
                    flush_cnt_d = '0;
                    out_data_d  = sat_data;
                    out_sat_d   = !in_range;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    state_d     = StHold;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            tap_cnt_q   <= '0;
            flush_cnt_q <= '0;
            prod_r_q    <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            prod_r_q    <= prod_r_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_mac_window.sv
// Directed bench for conv_mac_window: hand-computed Q5.11 windows, saturation, floor,
// output stall and mid-window reset.
module tb_conv_mac_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pixel;
    logic [15:0] in_weight;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int errors = 0;
    int checks = 0;

    conv_mac_window dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives 9 beats at negedges (optional idle gap after each), then checks latency and result.
    task automatic run_window(input string tag, input logic [15:0] p0, input logic [15:0] w0,
                              input logic [15:0] p, input logic [15:0] w, input bit gap,
                              input logic [15:0] exp_data, input logic exp_sat);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk({tag, "_ready"}, 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            in_pixel  = (i == 0) ? p0 : p;
            in_weight = (i == 0) ? w0 : w;
            if (gap && i != 8) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_pixel = 16'h7FFF;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_weight = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        run_window("t1_nine", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 1'b0, 16'h4800, 1'b0);
        release_out("t1");
        run_window("t2_pos_sat", 16'h0800, 16'h1000, 16'h0800, 16'h1000, 1'b0, 16'h7FFF, 1'b1);
        release_out("t2");
        run_window("t3_min_exact", 16'h8000, 16'h0800, 16'h0000, 16'h0000, 1'b0, 16'h8000, 1'b0);
        release_out("t3a");
        run_window("t3_neg_sat", 16'h8000, 16'h0800, 16'h8000, 16'h0800, 1'b0, 16'h8000, 1'b1);
        release_out("t3b");
        run_window("t4_tiny_pos", 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b0);
        release_out("t4a");
        run_window("t4_tiny_neg", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b0);
        release_out("t4b");

        // Output stall: result must hold and no beats may be absorbed.
        run_window("t5_first", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 1'b0, 16'h4800, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = i[0];
            in_pixel  = 16'h1000;
            in_weight = 16'h1000;
            @(negedge clk);
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_data", 32'(out_data), 32'h4800);
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("t5");
        run_window("t5_next", 16'h0400, 16'h0800, 16'h0400, 16'h0800, 1'b0, 16'h2400, 1'b0);
        release_out("t5n");

        // Reset after 4 beats must drop the partial sum.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pixel  = 16'h0800;
            in_weight = 16'h0800;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        run_window("t6_clean", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 1'b0, 16'h4800, 1'b0);
        release_out("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
